nested_gather: RTL and testbench
================================

// Module: nested_gather
// PURPOSE
//   Gather (upward) side of the nested-scope fan-out: the fan-out drives parent x to leaf a as x and leaf b as ~x.
//   This block collects one response from leaf a and one from leaf b per request and returns one result to the parent.
//   It checks the a/b complement relationship and flags a mismatch or a missing leaf (timeout).
//   Sits between a parent scope and two nested leaf scopes; one outstanding request at a time.
// PARAMETERS
//   WIDTH            8   leaf/parent data width in bits
//   TIMEOUT         15   COLLECT cycles allowed before a timeout response; legal range >= 1
//   CHECK_COMPLEMENT 1   1: rsp_err = (b != ~a); 0: rsp_err tied 0
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   req_valid    in   1      parent requests a gather
//   req_ready    out  1      high only in IDLE
//   a_valid      in   1      leaf a response valid
//   a_data       in   WIDTH  leaf a response (expected x)
//   a_ready      out  1      high in COLLECT until a captured
//   b_valid      in   1      leaf b response valid
//   b_data       in   WIDTH  leaf b response (expected ~x)
//   b_ready      out  1      high in COLLECT until b captured
//   rsp_valid    out  1      result valid to parent
//   rsp_ready    in   1      parent accepts result
//   rsp_data     out  WIDTH  captured a value (0 if a missing on timeout)
//   rsp_err      out  1      complement mismatch (both leaves present)
//   rsp_timeout  out  1      at least one leaf missing at timeout
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; a_got=b_got=0; timer=0; a_q=b_q=0; rsp_valid=rsp_err=rsp_timeout=0; rsp_data=0.
//   Handshakes: transfer on valid&ready at a rising edge; ready outputs decoded from state/flags only, never from valid.
//   FSM IDLE: req_ready=1. req_valid -> COLLECT; clear a_got, b_got, timer.
//   FSM COLLECT: a_ready=~a_got, b_ready=~b_got; capture a_q/b_q and set flag on transfer; timer += 1 each cycle.
//     Both flags set (incl. both leaves in same cycle, or last leaf this cycle) -> RESP, rsp_timeout=0.
//     Else timer==TIMEOUT-1 this cycle -> RESP with rsp_timeout=1 (i.e. exactly TIMEOUT cycles spent in COLLECT).
//     Completion and timeout in same cycle: completion wins, rsp_timeout=0.
//   FSM RESP: rsp_valid=1; rsp_data/err/timeout held stable until rsp_ready; rsp_ready -> IDLE, rsp_valid=0 next cycle.
//     rsp_data = a_got ? a_q : 0. rsp_err = CHECK_COMPLEMENT & a_got & b_got & (b_q != ~a_q); 0 on timeout.
//   Latency: req accepted edge N; COLLECT from N+1; leaves valid at N+1 -> rsp_valid at N+2.
//   Back-to-back: req_ready rises the cycle after the RESP handshake (no IDLE bypass).
//   Leaf valid outside COLLECT or after capture: ignored (ready low), no state change, leaf must hold.
//   Timer width $clog2(TIMEOUT+1); never wraps (leaves COLLECT first).
//   Reset mid-operation: any state -> IDLE immediately; partial captures discarded; no rsp emitted.
// TESTING
//   T1 req; a=8'h5A, b=8'hA5 same cycle N+1 -> rsp_valid at N+2, rsp_data=5A, err=0, timeout=0.
//   T2 a=8'h0F at N+1, b=8'h00 at N+4 -> rsp_data=0F, rsp_err=1, timeout=0; a_ready low from N+2.
//   T3 TIMEOUT=15, only b=8'hFF sent -> rsp_valid exactly 16 cycles after req edge, rsp_data=0, timeout=1, err=0.
//   T4 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0, new a/b valids not taken.
//   T5 rst_n pulsed low mid-COLLECT after a captured -> outputs reset at once; next req needs both leaves again.
//   T6 CHECK_COMPLEMENT=0, a=b=8'h33 -> rsp_err=0; last leaf arriving on timeout cycle -> timeout=0.

Source files
------------

// File: rtl/nested_gather.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nested_gather : collects one response from leaf a and leaf b per parent
// request and returns a single result, flagging mismatch or timeout. Rev 1.0
// ---------------------------------------------------------------------------
module nested_gather #(
  parameter int WIDTH            = 8,
  parameter int TIMEOUT          = 15,
  parameter int CHECK_COMPLEMENT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             rsp_timeout
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic          CHK  = (CHECK_COMPLEMENT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              a_got, b_got;
  logic [TW-1:0]     timer;
  logic [WIDTH-1:0]  a_q, b_q;

  logic              a_fire, b_fire, a_done, b_done;
  logic [WIDTH-1:0]  a_val, b_val;
  logic [WIDTH-1:0]  nx_data;
  logic              nx_err, nx_timeout;

  assign req_ready = (state == IDLE);
  assign a_ready   = (state == COLLECT) & ~a_got;
  assign b_ready   = (state == COLLECT) & ~b_got;
  assign rsp_valid = (state == RESP);

  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;
  assign a_done = a_got | a_fire;
  assign b_done = b_got | b_fire;
  // A leaf captured this very cycle counts as present for the result.
  assign a_val  = a_fire ? a_data : a_q;
  assign b_val  = b_fire ? b_data : b_q;

  assign nx_data    = a_done ? a_val : '0;
  assign nx_err     = CHK & a_done & b_done & (b_val != ~a_val);
  assign nx_timeout = ~(a_done & b_done);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = COLLECT;
      COLLECT: if ((a_done & b_done) || (timer == LAST)) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_got       <= 1'b0;
      b_got       <= 1'b0;
      timer       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_got <= 1'b0;
            b_got <= 1'b0;
            timer <= '0;
          end
        end
        COLLECT: begin
          if (a_fire) begin
            a_q   <= a_data;
            a_got <= 1'b1;
          end
          if (b_fire) begin
            b_q   <= b_data;
            b_got <= 1'b1;
          end
          timer <= timer + TW'(1);
          // Result registers load once on entry to RESP and then hold.
          if (state_nx == RESP) begin
            rsp_data    <= nx_data;
            rsp_err     <= nx_err;
            rsp_timeout <= nx_timeout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nested_gather.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nested_gather : randomized scoreboard bench for nested_gather. Rev 1.0
// ---------------------------------------------------------------------------
module tb_nested_gather;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       rsp_ready = 1'b0;

  logic       req_ready, a_ready, b_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_data;
  logic       req_ready0, a_ready0, b_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [7:0] rsp_data0;

  nested_gather #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CHECK_COMPLEMENT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  // Same stimulus, complement check disabled.
  nested_gather #(.WIDTH(8), .TIMEOUT(TIMEOUT), .CHECK_COMPLEMENT(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       timeout;
    int         at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       in_rsp = 1'b0, hs = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp    = 1'b0;
      hs        = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      if (hs) begin
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        hs     = 1'b0;
        in_rsp = 1'b0;
      end
      if (rsp_valid || rsp_valid0) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (t=%0t)", $time);
          end else begin
            cur = exp_q.pop_front();
            chk("rsp_latency", cyc, cur.at_cyc);
            chk("rsp_valid_nc", {31'd0, rsp_valid0}, 32'd1);
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, cur.data});
            chk("rsp_data_nc", {24'd0, rsp_data0}, {24'd0, cur.data});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
            chk("rsp_err_nc", {31'd0, rsp_err0}, 32'd0);
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, cur.timeout});
            chk("rsp_timeout_nc", {31'd0, rsp_timeout0}, {31'd0, cur.timeout});
          end
          in_rsp = 1'b1;
        end else begin
          chk("hold_data", {24'd0, rsp_data}, {24'd0, cur.data});
          chk("hold_flags", {30'd0, rsp_err, rsp_timeout}, {30'd0, cur.err, cur.timeout});
        end
        chk("resp_readies", {29'd0, req_ready, a_ready, b_ready}, 32'd0);
        rsp_ready = ($urandom_range(0, 2) == 0);
        hs        = rsp_ready;
      end else begin
        rsp_ready = $urandom_range(0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 300) begin
      req_valid = $urandom_range(0, 1);
      a_valid   = $urandom_range(0, 1);
      b_valid   = $urandom_range(0, 1);
      a_data    = $urandom;
      b_data    = $urandom;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      $display("FAIL wait_req_ready: got req_ready=0 expected 1 within 300 cycles");
      errors++;
      checks++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input int da, input int db);
    exp_t e;
    int   r, c, d;
    logic a_tk, b_tk, aw, bw;
    wait_idle();
    req_valid = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    r = cyc;
    if (da < TIMEOUT && db < TIMEOUT) begin
      d         = (da > db) ? da : db;
      e.data    = av;
      e.err     = (bv != ~av);
      e.timeout = 1'b0;
    end else begin
      d         = TIMEOUT - 1;
      e.data    = (da < TIMEOUT) ? av : 8'h00;
      e.err     = 1'b0;
      e.timeout = 1'b1;
    end
    e.at_cyc = r + d + 1;
    exp_q.push_back(e);
    a_tk = 1'b0;
    b_tk = 1'b0;
    c    = 0;
    while (!rsp_valid && c < TIMEOUT + 5) begin
      if (a_tk) chk("a_ready_after_capture", {31'd0, a_ready}, 32'd0);
      if (b_tk) chk("b_ready_after_capture", {31'd0, b_ready}, 32'd0);
      a_valid = (c >= da) && !a_tk;
      b_valid = (c >= db) && !b_tk;
      a_data  = a_valid ? av : 8'($urandom);
      b_data  = b_valid ? bv : 8'($urandom);
      aw = a_valid && a_ready;
      bw = b_valid && b_ready;
      @(negedge clk);
      a_tk = a_tk | aw;
      b_tk = b_tk | bw;
      c++;
    end
    if (!rsp_valid) begin
      errors++;
      checks++;
      $display("FAIL rsp_wait: got rsp_valid=0 expected 1 within %0d cycles", TIMEOUT + 5);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         rda, rdb;
    repeat (3) @(negedge clk);
    chk("reset_state", {27'd0, req_ready, a_ready, b_ready, rsp_valid, rsp_timeout},
        {27'd0, 5'b10000});
    chk("reset_data", {23'd0, rsp_err, rsp_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'hA5, 0, 0);          // both leaves together
    issue(8'h0F, 8'h00, 0, 3);          // mismatch, b late
    issue(8'h00, 8'hFF, NEVER, 0);      // a missing -> timeout
    issue(8'h33, 8'h33, 0, 1);          // mismatch seen only with check on
    issue(8'hC3, 8'h3C, 2, TIMEOUT-1);  // last leaf on timeout cycle
    issue(8'hC3, 8'h3C, 2, TIMEOUT);    // one cycle too late
    issue(8'h11, 8'hEE, NEVER, NEVER);  // nothing at all

    // Reset pulse mid-collect after a has been captured.
    wait_idle();
    req_valid = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    a_valid   = 1'b1;
    a_data    = 8'h77;
    @(negedge clk);
    a_valid   = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", {28'd0, req_ready, a_ready, b_ready, rsp_valid}, {28'd0, 4'b1000});
    chk("async_reset_data", {22'd0, rsp_timeout, rsp_err, rsp_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h77, 8'h88, NEVER, 0);      // earlier capture of a must be gone

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 1) != 0) ? ~ra : 8'($urandom);
      rda = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 2));
      rdb = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 2));
      issue(ra, rb, rda, rdb);
    end

    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
